onehot_pulse_decoder: RTL and testbench
=======================================

ONEHOT_PULSE_DECODER -- requirements
Module: onehot_pulse_decoder

Interface
REQ-001 SHALL have parameter: LEN_W, 4, width of the pulse-length input and the internal down-counter.
REQ-002 SHALL have port: clk  input  1  single clock; all state updates on the rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 SHALL have port: e  input  1  enable; 0 blocks acceptance and aborts any active pulse.
REQ-005 SHALL have port: in  input  3  binary code 0..7 to decode.
REQ-006 SHALL have port: in_valid  input  1  code on in is valid this cycle.
REQ-007 SHALL have port: in_ready  output  1  block can accept a code this cycle (combinational).
REQ-008 SHALL have port: len  input  LEN_W  pulse length in cycles, sampled at accept.
REQ-009 SHALL have port: out  output  8  registered one-hot decode of the accepted code.
REQ-010 SHALL have port: out_valid  output  1  registered; high while out carries a pulse.
REQ-011 SHALL have port: busy  output  1  registered; high in state DRIVE.
REQ-012 SHALL have port: acc_cnt  output  8  registered count of accepted codes, wraps 255->0.

Function
REQ-013 SHALL implement a two-state FSM: IDLE, DRIVE.
REQ-014 SHALL define accept as in_valid && in_ready on a rising clk edge.
REQ-015 SHALL drive in_ready = e && (state==IDLE || (state==DRIVE && cnt==1)).
REQ-016 On accept, SHALL load out = 8'b1 << in, out_valid=1, state=DRIVE, cnt = (len==0 ? 1 : len), visible the cycle after accept (latency 1).
REQ-017 SHALL hold out/out_valid stable for exactly cnt cycles; cnt decrements by 1 each DRIVE cycle.
REQ-018 When cnt==1 in DRIVE with no accept, SHALL return to IDLE with out=0, out_valid=0 next cycle.
REQ-019 When cnt==1 in DRIVE with accept, SHALL load the new code and length directly (back-to-back, no idle gap).
REQ-020 If e==0 in DRIVE, SHALL abort: next cycle out=0, out_valid=0, state=IDLE, cnt=0; no accept possible that cycle.
REQ-021 In IDLE, SHALL hold out=8'h00, out_valid=0 regardless of in/in_valid.
REQ-022 SHALL ignore in_valid when in_ready==0; in/len changes during DRIVE SHALL NOT alter out or the remaining length.
REQ-023 SHALL increment acc_cnt by 1 on every accept, modulo 256.
REQ-024 SHALL keep out strictly one-hot (exactly one bit) whenever out_valid==1 and all-zero otherwise.
REQ-025 busy SHALL equal (state==DRIVE) registered, matching out_valid.

Reset
REQ-026 On rst==1, SHALL set state=IDLE, cnt=0, out=8'h00, out_valid=0, busy=0, acc_cnt=8'h00 on the next rising edge.
REQ-027 rst SHALL take priority over accept, abort and countdown, including mid-pulse.
REQ-028 in_ready SHALL be 0 while rst==1.

Verification
REQ-029 Basic: e=1, in=3'd5, len=3, one-cycle in_valid -> out=8'h20, out_valid=1 for exactly 3 cycles starting 1 cycle after accept, then 8'h00; acc_cnt=1.
REQ-030 Zero length: in=3'd0, len=0 -> out=8'h01 for exactly 1 cycle.
REQ-031 Back-to-back: in=3'd7/len=2 then in_valid held with in=3'd2/len=2 -> out 8'h80,8'h80,8'h04,8'h04 with no gap; acc_cnt=2.
REQ-032 Abort: in=3'd4, len=10, drop e at 3rd DRIVE cycle -> out=8'h00, out_valid=0 next cycle, in_ready=0 until e=1.
REQ-033 Reset mid-pulse: rst=1 during DRIVE with out=8'h40 -> next cycle all outputs 0, acc_cnt=0; in_valid ignored while rst=1.
REQ-034 Wrap/blocking: 256 accepts -> acc_cnt=0; in_valid during non-final DRIVE cycles -> no accept, count unchanged.

Source files
------------

// File: rtl/onehot_pulse_decoder_if.sv
// Code/pulse bus for onehot_pulse_decoder: the code handshake, the pulse
// output and the status outputs.
interface onehot_pulse_decoder_if #(
   parameter int LEN_W = 4
);
   logic             e;
   logic [2:0]       in;
   logic             in_valid;
   logic             in_ready;
   logic [LEN_W-1:0] len;
   logic [7:0]       out;
   logic             out_valid;
   logic             busy;
   logic [7:0]       acc_cnt;

   modport master (
      output e, in, in_valid, len,
      input  in_ready, out, out_valid, busy, acc_cnt
   );

   modport slave (
      input  e, in, in_valid, len,
      output in_ready, out, out_valid, busy, acc_cnt
   );
endinterface

// File: rtl/onehot_pulse_decoder.sv
// Decodes an accepted 3-bit code to a one-hot pulse that is held on out for
// len cycles; a new code may be taken on the final cycle of a pulse.
module onehot_pulse_decoder #(
   parameter int LEN_W = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   onehot_pulse_decoder_if.slave  bus
);
   typedef enum logic {IDLE, DRIVE} state_t;

   state_t           state, state_n;
   logic [LEN_W-1:0] cnt, cnt_n;
   logic [7:0]       out_q, out_n;
   logic             ov_q, ov_n;
   logic [7:0]       acc_q, acc_n;
   logic             ready;
   logic             accept;
   logic             last;

   assign last   = (state == DRIVE) && (cnt == LEN_W'(1));
   assign ready  = !rst && bus.e && ((state == IDLE) || last);
   assign accept = bus.in_valid && ready;

   assign bus.in_ready  = ready;
   assign bus.out       = out_q;
   assign bus.out_valid = ov_q;
   assign bus.busy      = (state == DRIVE);
   assign bus.acc_cnt   = acc_q;

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      out_n   = out_q;
      ov_n    = ov_q;
      acc_n   = acc_q;
      if (accept) begin
         state_n = DRIVE;
         cnt_n   = (bus.len == '0) ? LEN_W'(1) : bus.len;
         out_n   = 8'b1 << bus.in;
         ov_n    = 1'b1;
         acc_n   = acc_q + 8'd1;
      end else if (state == DRIVE) begin
         // Abort and natural end both fall back to an empty, idle output.
         if (!bus.e || last) begin
            state_n = IDLE;
            cnt_n   = '0;
            out_n   = 8'h00;
            ov_n    = 1'b0;
         end else begin
            cnt_n = cnt - LEN_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
         out_q <= 8'h00;
         ov_q  <= 1'b0;
         acc_q <= 8'h00;
      end else begin
         state <= state_n;
         cnt   <= cnt_n;
         out_q <= out_n;
         ov_q  <= ov_n;
         acc_q <= acc_n;
      end
   end
endmodule

// File: tb/tb_onehot_pulse_decoder.sv
// Directed-vector bench for onehot_pulse_decoder with hand-computed
// expected values.
module tb_onehot_pulse_decoder;
   logic clk;
   logic rst;
   int   checks;
   int   failures;

   onehot_pulse_decoder_if #(.LEN_W(4)) bus ();

   onehot_pulse_decoder #(.LEN_W(4)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst          = 1'b1;
      bus.e        = 1'b0;
      bus.in       = 3'd0;
      bus.in_valid = 1'b0;
      bus.len      = 4'd0;
      tick();
      tick();
      chk("rst_out", 32'(bus.out), 32'h00);
      chk("rst_ov", 32'(bus.out_valid), 32'h0);
      chk("rst_busy", 32'(bus.busy), 32'h0);
      chk("rst_acc", 32'(bus.acc_cnt), 32'h00);
      bus.e = 1'b1;
      #1;
      chk("rst_rdy", 32'(bus.in_ready), 32'h0);
      rst = 1'b0;
      #1;
      chk("idle_rdy", 32'(bus.in_ready), 32'h1);

      // Basic pulse: code 5 for 3 cycles, in/len wiggled mid-pulse
      bus.in = 3'd5; bus.len = 4'd3; bus.in_valid = 1'b1;
      tick();
      bus.in = 3'd1; bus.len = 4'd9;
      #1;
      chk("b_c1", 32'(bus.out), 32'h20);
      chk("b_ov1", 32'(bus.out_valid), 32'h1);
      chk("b_rdy1", 32'(bus.in_ready), 32'h0);
      tick();
      bus.in_valid = 1'b0;
      chk("b_c2", 32'(bus.out), 32'h20);
      chk("b_acc2", 32'(bus.acc_cnt), 32'h1);
      tick();
      chk("b_c3", 32'(bus.out), 32'h20);
      chk("b_rdy3", 32'(bus.in_ready), 32'h1);
      tick();
      chk("b_end", 32'(bus.out), 32'h00);
      chk("b_endov", 32'(bus.out_valid), 32'h0);
      chk("b_busy", 32'(bus.busy), 32'h0);
      chk("b_acc", 32'(bus.acc_cnt), 32'h1);

      // Zero length gives a single-cycle pulse
      bus.in = 3'd0; bus.len = 4'd0; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      chk("z_c1", 32'(bus.out), 32'h01);
      chk("z_busy", 32'(bus.busy), 32'h1);
      tick();
      chk("z_end", 32'(bus.out), 32'h00);
      chk("z_acc", 32'(bus.acc_cnt), 32'h2);

      // Back-to-back: 7/len2 then 2/len2 with valid held
      bus.in = 3'd7; bus.len = 4'd2; bus.in_valid = 1'b1;
      tick();
      bus.in = 3'd2;
      chk("bb_1", 32'(bus.out), 32'h80);
      tick();
      chk("bb_2", 32'(bus.out), 32'h80);
      tick();
      bus.in_valid = 1'b0;
      chk("bb_3", 32'(bus.out), 32'h04);
      chk("bb_ov3", 32'(bus.out_valid), 32'h1);
      tick();
      chk("bb_4", 32'(bus.out), 32'h04);
      tick();
      chk("bb_end", 32'(bus.out), 32'h00);
      chk("bb_acc", 32'(bus.acc_cnt), 32'h4);

      // Abort: drop e on the 3rd drive cycle
      bus.in = 3'd4; bus.len = 4'd10; bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      tick();
      tick();
      bus.e = 1'b0;
      #1;
      chk("ab_c3", 32'(bus.out), 32'h10);
      chk("ab_rdy", 32'(bus.in_ready), 32'h0);
      tick();
      chk("ab_out", 32'(bus.out), 32'h00);
      chk("ab_ov", 32'(bus.out_valid), 32'h0);
      chk("ab_busy", 32'(bus.busy), 32'h0);
      bus.in_valid = 1'b1;
      #1;
      chk("ab_rdy2", 32'(bus.in_ready), 32'h0);
      tick();
      chk("ab_blk", 32'(bus.out_valid), 32'h0);
      chk("ab_acc", 32'(bus.acc_cnt), 32'h5);
      bus.in_valid = 1'b0;
      bus.e = 1'b1;
      #1;
      chk("ab_rdy3", 32'(bus.in_ready), 32'h1);

      // Reset mid-pulse
      bus.in = 3'd6; bus.len = 4'd5; bus.in_valid = 1'b1;
      tick();
      chk("rm_c1", 32'(bus.out), 32'h40);
      chk("rm_acc1", 32'(bus.acc_cnt), 32'h6);
      rst = 1'b1;
      #1;
      chk("rm_rdy", 32'(bus.in_ready), 32'h0);
      tick();
      chk("rm_out", 32'(bus.out), 32'h00);
      chk("rm_ov", 32'(bus.out_valid), 32'h0);
      chk("rm_busy", 32'(bus.busy), 32'h0);
      chk("rm_acc", 32'(bus.acc_cnt), 32'h00);
      tick();
      chk("rm_acc2", 32'(bus.acc_cnt), 32'h00);
      rst = 1'b0;
      bus.in_valid = 1'b0;
      tick();

      // Wrap: 256 back-to-back single-cycle accepts
      bus.len = 4'd0;
      bus.in_valid = 1'b1;
      for (int i = 0; i < 256; i++) begin
         bus.in = 3'(i);
         tick();
         if (i == 254)
            chk("w_255", 32'(bus.acc_cnt), 32'hff);
         if (i == 100)
            chk("w_oh", 32'(bus.out), 32'h10);
      end
      bus.in_valid = 1'b0;
      chk("w_acc", 32'(bus.acc_cnt), 32'h00);
      chk("w_last", 32'(bus.out), 32'h80);
      tick();
      chk("w_idle", 32'(bus.out_valid), 32'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
